// File: rtl/alarm_set_controller.sv
// alarm_set_controller
//   Front-panel mode/edit sequencer for the alarm clock. MODE walks the user
//   through RUN -> T_HOUR -> T_MIN -> A_HOUR -> A_MIN -> RUN. UP/DOWN adjust
//   the field being edited, with wrap-around. Leaving T_MIN with MODE commits
//   the edited time to the timekeeper via time_load. The block also owns the
//   alarm time/enable registers and the blink signal for the edited digit.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   mode_pulse          1-cycle MODE button pulse
//   up_pulse            1-cycle UP button pulse (auto-repeat)
//   down_pulse          1-cycle DOWN button pulse (auto-repeat)
//   cur_hour, cur_min   live time from the timekeeper
//   set_hour, set_min   edited time, meaningful only while time_load=1
//   time_load           1-cycle strobe: timekeeper loads set_hour/set_min
//   alarm_hour/min/en   alarm registers
//   mode                0=RUN 1=T_HOUR 2=T_MIN 3=A_HOUR 4=A_MIN
//   blink               1 = edited field visible, 0 = blanked
//
// state   | meaning
// RUN     | normal display; UP toggles alarm_en
// T_HOUR  | editing set_hour (captured from cur_hour on entry)
// T_MIN   | editing set_min; MODE commits with time_load
// A_HOUR  | editing alarm_hour in place
// A_MIN   | editing alarm_min in place
module alarm_set_controller #(
    parameter int unsigned BLINK_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_pulse,
    input  logic       up_pulse,
    input  logic       down_pulse,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       time_load,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic [2:0] mode,
    output logic       blink
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_T_HOUR = 3'd1,
        ST_T_MIN  = 3'd2,
        ST_A_HOUR = 3'd3,
        ST_A_MIN  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    set_hour_q, set_hour_d, alarm_hour_q, alarm_hour_d;
    logic [5:0]    set_min_q, set_min_d, alarm_min_q, alarm_min_d;
    logic          alarm_en_q, alarm_en_d;
    logic          time_load_q, time_load_d;
    logic          blink_q, blink_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    logic any_pulse;
    logic step;
    logic step_up;

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
        else    return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
        if (up) return (m == 6'd59) ? 6'd0 : m + 6'd1;
        else    return (m == 6'd0) ? 6'd59 : m - 6'd1;
    endfunction

    // UP and DOWN in the same cycle cancel each other out.
    assign any_pulse = mode_pulse | up_pulse | down_pulse;
    assign step      = up_pulse ^ down_pulse;
    assign step_up   = up_pulse;

    always_comb begin
        state_d      = state_q;
        set_hour_d   = set_hour_q;
        set_min_d    = set_min_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_en_d   = alarm_en_q;
        time_load_d  = 1'b0;
        timeout_d    = timeout_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;

        if (mode_pulse) begin
            case (state_q)
                ST_RUN: begin
                    state_d    = ST_T_HOUR;
                    set_hour_d = cur_hour;
                    set_min_d  = cur_min;
                end
                ST_T_HOUR: state_d = ST_T_MIN;
                ST_T_MIN: begin
                    state_d     = ST_A_HOUR;
                    time_load_d = 1'b1;
                end
                ST_A_HOUR: state_d = ST_A_MIN;
                default:   state_d = ST_RUN;
            endcase
        end else if (step) begin
            case (state_q)
                ST_RUN:    alarm_en_d   = alarm_en_q ^ step_up;
                ST_T_HOUR: set_hour_d   = hour_step(set_hour_q, step_up);
                ST_T_MIN:  set_min_d    = min_step(set_min_q, step_up);
                ST_A_HOUR: alarm_hour_d = hour_step(alarm_hour_q, step_up);
                default:   alarm_min_d  = min_step(alarm_min_q, step_up);
            endcase
        end else if (state_q != ST_RUN && timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Inactivity exit: a pending time edit is simply dropped.
            state_d = ST_RUN;
        end

        // Any user activity restarts both the timeout and the blink phase,
        // so the field stays visible while it is being adjusted.
        if (state_d == ST_RUN || any_pulse || state_d != state_q) begin
            timeout_d   = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else begin
            timeout_d = timeout_q + TW'(1);
            if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            set_hour_q   <= '0;
            set_min_q    <= '0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_en_q   <= 1'b0;
            time_load_q  <= 1'b0;
            timeout_q    <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            set_hour_q   <= set_hour_d;
            set_min_q    <= set_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_en_q   <= alarm_en_d;
            time_load_q  <= time_load_d;
            timeout_q    <= timeout_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign mode       = state_q;
    assign set_hour   = set_hour_q;
    assign set_min    = set_min_q;
    assign alarm_hour = alarm_hour_q;
    assign alarm_min  = alarm_min_q;
    assign alarm_en   = alarm_en_q;
    assign time_load  = time_load_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Testbench for alarm_set_controller: directed button sequences, a high-level
// model checked on every cycle, and literal expectations at key points.
module tb_alarm_set_controller;

    localparam int TO = 100;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       up_pulse = 1'b0;
    logic       down_pulse = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       time_load;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic [2:0] mode;
    logic       blink;

    alarm_set_controller #(.BLINK_CYCLES(BL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .mode_pulse(mode_pulse), .up_pulse(up_pulse), .down_pulse(down_pulse),
        .cur_hour(cur_hour), .cur_min(cur_min),
        .set_hour(set_hour), .set_min(set_min), .time_load(time_load),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    // Model state: plain integers, idle = cycles since the last event.
    int m_mode, m_sh, m_sm, m_tl, m_ah, m_am, m_en, m_blink, m_idle;
    bit chk_on = 1'b0;
    int checks = 0;
    int errors = 0;
    int tl_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (time_load === 1'b1) tl_cnt++;
        if (chk_on) begin
            chk("mode", int'(mode), m_mode);
            chk("set_hour", int'(set_hour), m_sh);
            chk("set_min", int'(set_min), m_sm);
            chk("time_load", int'(time_load), m_tl);
            chk("alarm_hour", int'(alarm_hour), m_ah);
            chk("alarm_min", int'(alarm_min), m_am);
            chk("alarm_en", int'(alarm_en), m_en);
            chk("blink", int'(blink), m_blink);
        end
    end

    task automatic tick(input bit m, input bit u, input bit d, input bit r);
        int n_mode, n_sh, n_sm, n_tl, n_ah, n_am, n_en, n_idle, delta;
        @(negedge clk);
        #1;
        reset = r; mode_pulse = m; up_pulse = u; down_pulse = d;
        n_mode = m_mode; n_sh = m_sh; n_sm = m_sm; n_tl = 0;
        n_ah = m_ah; n_am = m_am; n_en = m_en;
        delta = u ? 1 : -1;
        if (r) begin
            n_mode = 0; n_sh = 0; n_sm = 0; n_ah = 0; n_am = 0; n_en = 0;
        end else if (m) begin
            if (m_mode == 0) begin
                n_sh = int'(cur_hour); n_sm = int'(cur_min);
            end
            if (m_mode == 2) n_tl = 1;
            n_mode = (m_mode + 1) % 5;
        end else if (u != d) begin
            case (m_mode)
                0: if (u) n_en = 1 - m_en;
                1: n_sh = (m_sh + 24 + delta) % 24;
                2: n_sm = (m_sm + 60 + delta) % 60;
                3: n_ah = (m_ah + 24 + delta) % 24;
                default: n_am = (m_am + 60 + delta) % 60;
            endcase
        end else if (m_mode != 0 && m_idle == TO - 1) begin
            n_mode = 0;
        end
        if (r || n_mode == 0 || m || u || d || n_mode != m_mode) n_idle = 0;
        else n_idle = m_idle + 1;
        @(posedge clk);
        #1;
        m_mode = n_mode; m_sh = n_sh; m_sm = n_sm; m_tl = n_tl;
        m_ah = n_ah; m_am = n_am; m_en = n_en; m_idle = n_idle;
        m_blink = (n_mode == 0) ? 1 : (((n_idle / BL) % 2) == 0 ? 1 : 0);
        if (r) chk_on = 1'b1;
    endtask

    task automatic do_reset();  tick(0, 0, 0, 1); tick(0, 0, 0, 0); endtask
    task automatic press_mode(); tick(1, 0, 0, 0); endtask
    task automatic press_up();   tick(0, 1, 0, 0); endtask
    task automatic press_down(); tick(0, 0, 1, 0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    int tl_mark;

    initial begin
        // 1: basic edit and commit
        cur_hour = 5'd14; cur_min = 6'd30;
        do_reset();
        chk("rst_mode", int'(mode), 0);
        chk("rst_blink", int'(blink), 1);
        chk("rst_alarm_en", int'(alarm_en), 0);
        chk("rst_set_min", int'(set_min), 0);
        press_mode();
        chk("capture_hour", int'(set_hour), 14);
        chk("capture_min", int'(set_min), 30);
        for (int i = 0; i < 3; i++) press_up();
        press_mode();
        for (int i = 0; i < 31; i++) press_down();
        tl_mark = tl_cnt;
        press_mode();
        chk("t1_set_hour", int'(set_hour), 17);
        chk("t1_set_min", int'(set_min), 59);
        chk("t1_time_load", int'(time_load), 1);
        chk("t1_mode", int'(mode), 3);
        idle(1);
        chk("t1_time_load_off", int'(time_load), 0);
        chk("t1_tl_once", tl_cnt - tl_mark, 1);
        press_mode(); press_mode();
        chk("t1_back_run", int'(mode), 0);

        // 2: wrap-around
        cur_hour = 5'd23; cur_min = 6'd5;
        press_mode();
        press_up();
        chk("wrap_hour_up", int'(set_hour), 0);
        press_down();
        chk("wrap_hour_down", int'(set_hour), 23);
        tick(0, 1, 1, 0);
        chk("up_down_ignored", int'(set_hour), 23);
        do_reset();
        for (int i = 0; i < 4; i++) press_mode();
        chk("a_min_mode", int'(mode), 4);
        press_down();
        chk("wrap_min_down", int'(alarm_min), 59);
        press_up();
        chk("wrap_min_up", int'(alarm_min), 0);
        press_mode();

        // 3: alarm enable toggle and pulse priority
        press_up();
        chk("en_on", int'(alarm_en), 1);
        press_up();
        chk("en_off", int'(alarm_en), 0);
        press_down();
        chk("en_down_ignored", int'(alarm_en), 0);
        cur_hour = 5'd9; cur_min = 6'd12;
        press_mode();
        tick(1, 1, 0, 0);
        chk("prio_mode", int'(mode), 2);
        chk("prio_hour", int'(set_hour), 9);
        do_reset();

        // 4: timeout and blink
        press_mode(); press_mode();
        tl_mark = tl_cnt;
        idle(TO - 1);
        chk("to_tmin_hold", int'(mode), 2);
        idle(1);
        chk("to_tmin_exit", int'(mode), 0);
        chk("to_no_load", tl_cnt - tl_mark, 0);
        do_reset();
        press_mode(); press_mode(); press_mode();
        press_up();
        chk("blink_after_pulse", int'(blink), 1);
        idle(BL - 1);
        chk("blink_still_on", int'(blink), 1);
        idle(1);
        chk("blink_off", int'(blink), 0);
        idle(BL);
        chk("blink_on_again", int'(blink), 1);
        idle(TO - 1 - 2 * BL);
        chk("to_ahour_hold", int'(mode), 3);
        idle(1);
        chk("to_ahour_exit", int'(mode), 0);
        chk("to_alarm_kept", int'(alarm_hour), 1);
        chk("run_blink", int'(blink), 1);

        // 5: reset mid-edit
        do_reset();
        press_up();
        press_mode(); press_mode(); press_mode();
        press_up();
        press_mode(); press_up();
        press_mode();
        cur_hour = 5'd6; cur_min = 6'd40;
        press_mode(); press_mode();
        press_up(); press_up();
        chk("pre_rst_min", int'(set_min), 42);
        tl_mark = tl_cnt;
        tick(0, 0, 0, 1);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_set_min", int'(set_min), 0);
        chk("mid_rst_alarm_hour", int'(alarm_hour), 0);
        chk("mid_rst_alarm_min", int'(alarm_min), 0);
        chk("mid_rst_alarm_en", int'(alarm_en), 0);
        idle(3);
        chk("mid_rst_no_load", tl_cnt - tl_mark, 0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
